acc_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit accumulate datapath between two requesters. Each requester asks for a job of LEN operands and is granted exclusive use. The block then clears the accumulator, streams the operands in with a valid/ready handshake and adds each one. At the end it returns the sum, a sticky overflow flag and a one-cycle done pulse. It sits between the ALU-side operand sources and the accumulator register, and contains that register.

---
 rtl/acc_rr_scheduler.sv | 120 ++++++++++++
 tb/tb_acc_rr_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/acc_rr_scheduler.sv
// Round-robin scheduler that shares one accumulate datapath between two requesters.
// A granted job clears the accumulator, then adds LEN operands taken over a valid/ready
// handshake. It finishes with a one-cycle done pulse to the owner.
module acc_rr_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [LEN_W-1:0] len0,
    input  logic [WIDTH-1:0] dat0,
    input  logic             vld0,
    output logic             rdy0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len1,
    input  logic [WIDTH-1:0] dat1,
    input  logic             vld1,
    output logic             rdy1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [1:0]       done
);

    typedef enum logic [1:0] {StIdle, StClear, StAccum, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    // High when requester 1 has priority on a tie, i.e. requester 0 was served last.
    logic             prio1_q, prio1_d;

    logic             win0;
    logic             hs;
    logic [WIDTH-1:0] dat_sel;
    logic [WIDTH:0]   sum;

    // State register and datapath registers; reset wins over any handshake or grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= 2'b00;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            prio1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            prio1_q  <= prio1_d;
        end
    end

    // Next-state: arbitration, job setup, accumulation and completion.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        prio1_d  = prio1_q;

        win0    = req0 && (!req1 || !prio1_q);
        dat_sel = gnt_q[0] ? dat0 : dat1;
        // Owner's rdy is high throughout ACCUM, so its vld alone completes a handshake.
        hs      = (state_q == StAccum) && (gnt_q[0] ? vld0 : vld1);
        sum     = {1'b0, result_q} + {1'b0, dat_sel};

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    gnt_d   = win0 ? 2'b01 : 2'b10;
                    cnt_d   = win0 ? len0 : len1;
                    state_d = StClear;
                end
            end
            StClear: begin
                result_d = '0;
                ovf_d    = 1'b0;
                state_d  = (cnt_q == '0) ? StDone : StAccum;
            end
            StAccum: begin
                if (hs) begin
                    result_d = sum[WIDTH-1:0];
                    ovf_d    = ovf_q | sum[WIDTH];
                    cnt_d    = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                prio1_d = gnt_q[0];
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state and owner.
    always_comb begin
        busy = (state_q != StIdle);
        rdy0 = (state_q == StAccum) && gnt_q[0];
        rdy1 = (state_q == StAccum) && gnt_q[1];
        done = (state_q == StDone) ? gnt_q : 2'b00;
    end

    assign gnt    = gnt_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Bench for acc_rr_scheduler: directed and random jobs checked against a job-level model.
module tb_acc_rr_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1, vld0, vld1;
    logic [3:0] len0, len1;
    logic [7:0] dat0, dat1;
    logic       rdy0, rdy1, busy, ovf;
    logic [1:0] gnt, done;
    logic [7:0] result;

    int   checks = 0;
    int   errors = 0;
    // Model: requester 1 wins a tie when requester 0 was served last.
    bit   m_prio1 = 1'b0;
    logic [7:0] fixed_ops [16];

    acc_rr_scheduler #(.WIDTH(8), .LEN_W(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0),
        .len0   (len0),
        .dat0   (dat0),
        .vld0   (vld0),
        .rdy0   (rdy0),
        .req1   (req1),
        .len1   (len1),
        .dat1   (dat1),
        .vld1   (vld1),
        .rdy1   (rdy1),
        .gnt    (gnt),
        .busy   (busy),
        .result (result),
        .ovf    (ovf),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One job from an idle cycle. Stalls: random up to max_stall, plus 'forced' stall
    // cycles before operand index 1. Returns at the negedge of the idle cycle after DONE.
    task automatic job(input bit r0, input bit r1, input int l0, input int l1,
                       input bit rnd, input int max_stall, input int forced);
        int own, len, total, k, stalls, forced_left;
        bit stall;
        logic [7:0] ops [16];
        logic [1:0] oh;
        own   = (r0 && (!r1 || !m_prio1)) ? 0 : 1;
        oh    = (own == 0) ? 2'b01 : 2'b10;
        len   = (own == 0) ? l0 : l1;
        total = 0;
        for (int i = 0; i < len; i++) begin
            ops[i] = rnd ? 8'($urandom_range(0, 255)) : fixed_ops[i];
            total += int'(ops[i]);
        end
        req0 = r0; req1 = r1; len0 = 4'(l0); len1 = 4'(l1);
        @(posedge clock); #1;
        // Owner drops req mid-job; junk valid data during CLEAR must not be taken.
        req0 = 1'b0; req1 = 1'b0; len0 = 4'($urandom); len1 = 4'($urandom);
        vld0 = 1'b1; vld1 = 1'b1; dat0 = 8'hff; dat1 = 8'hff;
        @(negedge clock);
        check("clear_gnt", 32'(gnt), 32'(oh));
        check("clear_busy", 32'(busy), 32'd1);
        check("clear_rdy", 32'({rdy1, rdy0}), 32'd0);
        @(posedge clock); #1;
        k = 0; stalls = 0; forced_left = forced;
        while (k < len) begin
            stall = 1'b0;
            if (k == 1 && forced_left > 0) begin
                stall = 1'b1;
                forced_left--;
            end else if (stalls < max_stall && $urandom_range(0, 2) == 0) begin
                stall = 1'b1;
                stalls++;
            end
            if (own == 0) begin
                vld0 = !stall; dat0 = stall ? 8'($urandom) : ops[k];
                vld1 = 1'($urandom); dat1 = 8'($urandom);
            end else begin
                vld1 = !stall; dat1 = stall ? 8'($urandom) : ops[k];
                vld0 = 1'($urandom); dat0 = 8'($urandom);
            end
            @(negedge clock);
            check("accum_rdy", 32'({rdy1, rdy0}), 32'(oh));
            check("accum_done", 32'(done), 32'd0);
            @(posedge clock); #1;
            if (!stall) k++;
        end
        vld0 = 1'b0; vld1 = 1'b0;
        @(negedge clock);
        check("done_pulse", 32'(done), 32'(oh));
        check("done_result", 32'(result), 32'(total % 256));
        check("done_ovf", 32'(ovf), 32'(total >= 256));
        check("done_rdy", 32'({rdy1, rdy0}), 32'd0);
        m_prio1 = (own == 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_gnt", 32'(gnt), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_result_hold", 32'(result), 32'(total % 256));
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; vld0 = 0; vld1 = 0;
        len0 = 0; len1 = 0; dat0 = 0; dat1 = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'({rdy1, rdy0}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic job
        fixed_ops[0] = 8'h10; fixed_ops[1] = 8'h20; fixed_ops[2] = 8'h30;
        job(1, 0, 3, 0, 0, 0, 0);
        // Wrap and overflow, then overflow cleared by the next job
        fixed_ops[0] = 8'hb2; fixed_ops[1] = 8'h62;
        job(0, 1, 0, 2, 0, 0, 0);
        fixed_ops[0] = 8'h01;
        job(0, 1, 0, 1, 0, 0, 0);
        // Stall of three cycles between operands
        fixed_ops[0] = 8'h05; fixed_ops[1] = 8'h07;
        job(1, 0, 2, 0, 0, 0, 3);
        // Zero-length job
        job(1, 0, 0, 0, 0, 0, 0);

        // Reset mid-job, then fresh arbitration state
        req0 = 1; len0 = 4;
        @(posedge clock); #1;
        req0 = 0;
        @(posedge clock); #1;
        vld0 = 1; dat0 = 8'h11;
        @(posedge clock); #1;
        reset = 1; req1 = 1;
        @(posedge clock); #1;
        reset = 0; req1 = 0; vld0 = 0;
        @(negedge clock);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("midrst_idle_done", 32'(done), 32'd0);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        m_prio1 = 1'b0;
        // Tie right after reset must go to requester 0
        fixed_ops[0] = 8'h22;
        job(1, 1, 1, 1, 0, 0, 0);

        // Arbitration: both requesting, alternating owners
        for (int i = 0; i < 4; i++) job(1, 1, 1, 1, 1, 0, 0);

        // Random jobs with random stalls
        for (int i = 0; i < 25; i++) begin
            bit a, b;
            a = 1'($urandom);
            b = a ? 1'($urandom) : 1'b1;
            job(a, b, $urandom_range(0, 15), $urandom_range(0, 15), 1, 3, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
